led_pattern_monitor: RTL and testbench
======================================

# led_pattern_monitor

Passive checker on the 16-bit `led` bus driven by `led_FSM`. It decodes the bouncing one-hot pattern (bit 0 → bit 15 → bit 0 …) into position and direction, counts completed sweeps, and flags the first illegal transition or stall with a sticky error code. It sits beside `led_FSM` in the top level and in simulation, and never drives the LEDs.

## Interface
- `STALL_CYCLES`, default 1000: clock cycles without any `led` change in TRACK before a stall error is raised.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `led` input 16: LED bus observed from `led_FSM`.
- `clr` input 1: synchronous single-cycle pulse; clears the error and the sweep count and restarts synchronisation.
- `pos` output 4: index of the currently lit LED.
- `dir` output 1: 0 = moving up (toward bit 15), 1 = moving down.
- `locked` output 1: high while in TRACK.
- `sweep_cnt` output 8: number of completed round trips, modulo 256.
- `err` output 1: sticky error flag.
- `err_code` output 2: 0 none, 1 not one-hot, 2 illegal step, 3 stall.

## Operation
- `led_q` register holds the previous `led` value; `change = (led != led_q)`.
- `onehot` is true when exactly one bit of `led` is set; `npos` is the index of that bit.
- States:
  - SYNC: on a change to a one-hot value, capture `pos = npos` → ARM.
  - ARM:
    - On a change to one-hot `npos` with |`npos`−`pos`| == 1: set `dir = (npos < pos)`, `pos = npos`, assert `locked` → TRACK.
    - On a change to a non-adjacent one-hot value: recapture `pos`, stay in ARM.
    - On a change to a non-one-hot value: → SYNC.
  - TRACK: on a change, the expected next position is `pos+1` if `dir`=0, else `pos−1`.
    - At `pos`=15 with `dir`=0, expect 14 and flip `dir` to 1.
    - At `pos`=0 with `dir`=1, expect 1 and flip `dir` to 0.
    - A non-one-hot value (including all-zero) → ERROR with code 1.
    - A one-hot value other than the expected one → ERROR with code 2.
    - `sweep_cnt` increments when `pos` moves 1 → 0.
  - ERROR: `err`=1, `locked`=0; `pos`, `dir` and `sweep_cnt` are frozen. The state is held until `clr`.
- `clr` in any state: → SYNC, `err`=0, `err_code`=0, `sweep_cnt`=0, `locked`=0; `pos` and `dir` are unchanged. When `clr` and `change` occur in the same cycle, `clr` wins and the change is ignored.
- Only the first error is recorded; later violations do not overwrite `err_code`.

## Timing
- Reset values: `pos`=0, `dir`=0, `locked`=0, `sweep_cnt`=0, `err`=0, `err_code`=0, `led_q`=16'h0000, state SYNC, stall counter 0.
- All outputs are registered. An `led` change sampled at edge N is reflected on `pos`, `dir`, `err` and `sweep_cnt` after edge N.
- Stall counter:
  - Cleared on every change and on every cycle outside TRACK.
  - Increments on each TRACK cycle without a change.
  - Raises ERROR with code 3 on the edge where it reaches `STALL_CYCLES`.
- Counter width is `$clog2(STALL_CYCLES+1)`.
- Reset asserted mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Configuration
- `LED_MON_STALL_EN`:
  - Defined: stall counter and error code 3 are present.
  - Undefined: no counter is built, `STALL_CYCLES` is ignored, code 3 is never produced, and the ports are unchanged.

## Structure
- Package `led_mon_pkg` holds:
  - `mon_state_t` enum: SYNC, ARM, TRACK, ERROR.
  - `mon_err_t` enum: ERR_NONE, ERR_ONEHOT, ERR_STEP, ERR_STALL.
  - Constant `LED_W` = 16.
- One combinational sub-module, `led_onehot_enc`, maps `led` to `onehot` and `npos`.

## Test plan
- Reset, then drive `led` 0001, 0002, 0004 with 10 idle cycles between values → `locked`=1 after the 0002 change; `pos`=2, `dir`=0, `err`=0.
- Drive a full bounce 0001 → 8000 → 0001 → `dir` flips to 1 on 8000→4000 and back to 0 on 0001→0002; `sweep_cnt`=1 after 0002→0001.
- In TRACK at `pos`=3, drive 0010 → 0030 → `err`=1, `err_code`=1, `locked`=0. Then drive 0100 → `err_code` stays 1.
- In TRACK at `pos`=5 with `dir`=0, drive 0100 → `err_code`=2. Pulse `clr` → `err`=0, `sweep_cnt`=0, state SYNC.
- With `LED_MON_STALL_EN` defined and `STALL_CYCLES`=8, hold `led` constant in TRACK → `err_code`=3 exactly 8 cycles after the last change. Without the macro → `err` stays 0.
- Pull `reset` low mid-TRACK with `sweep_cnt`=5 → all outputs return to 0 immediately; after release, relock requires two adjacent one-hot changes.

Source files
------------

// File: rtl/led_mon_pkg.sv
// Shared types and constants for the LED bounce-pattern monitor.
// Holds the state/error encodings and a small position-adjacency helper.
package led_mon_pkg;

  localparam int LED_W = 16;
  localparam int POS_W = $clog2(LED_W);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ONEHOT = 2'd1,
    ERR_STEP   = 2'd2,
    ERR_STALL  = 2'd3
  } mon_err_t;

  // True when b sits one position above or below a, without wrapping 15<->0.
  function automatic logic pos_adjacent(input logic [POS_W-1:0] a,
                                        input logic [POS_W-1:0] b);
    logic up_ok;
    logic dn_ok;
    up_ok = (a != {POS_W{1'b1}}) && (b == a + POS_W'(1));
    dn_ok = (a != {POS_W{1'b0}}) && (b == a - POS_W'(1));
    return up_ok || dn_ok;
  endfunction

endpackage

// File: rtl/led_onehot_enc.sv
// Purpose: flags a one-hot LED bus and encodes the index of the lit bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a passive decoder with no flow control.
module led_onehot_enc
  import led_mon_pkg::*;
(
  input  logic [LED_W-1:0] led,
  output logic             onehot,
  output logic [POS_W-1:0] npos
);

  // OR of set-bit indices is only meaningful when onehot is true.
  always_comb begin
    npos = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (led[i]) begin
        npos = npos | POS_W'(i);
      end
    end
  end

  assign onehot = (led != '0) && ((led & (led - LED_W'(1))) == '0);

endmodule

// File: rtl/led_pattern_monitor.sv
// Purpose: tracks the bouncing one-hot LED pattern, counts sweeps, latches the first fault.
// Latency: one cycle from an led change to pos/dir/locked/err/sweep_cnt; stall check built only with LED_MON_STALL_EN.
// Backpressure: none; observes led passively and never stalls or drives the bus.
module led_pattern_monitor
  import led_mon_pkg::*;
#(
  parameter int STALL_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] led,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             locked,
  output logic [7:0]       sweep_cnt,
  output logic             err,
  output logic [1:0]       err_code
);

  logic [LED_W-1:0] led_q;
  mon_state_t       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [7:0]       sweep_q, sweep_d;
  logic             err_q, err_d;
  mon_err_t         code_q, code_d;
  logic             locked_q, locked_d;

  logic             change;
  logic             onehot;
  logic [POS_W-1:0] npos;
  logic             stall_hit;
  logic [POS_W-1:0] exp_pos;
  logic             exp_dir;

  led_onehot_enc u_enc (
    .led    (led),
    .onehot (onehot),
    .npos   (npos)
  );

  assign change = (led != led_q);

`ifdef LED_MON_STALL_EN
  localparam int CNT_W = $clog2(STALL_CYCLES + 1);

  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d   = '0;
    stall_hit = 1'b0;
    if ((state_q == TRACK) && !change) begin
      stall_d   = stall_q + CNT_W'(1);
      stall_hit = (stall_d == CNT_W'(STALL_CYCLES));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  localparam int unused_stall_cycles = STALL_CYCLES;

  assign stall_hit = 1'b0;
`endif

  // Direction turns around at the end stops rather than wrapping.
  always_comb begin
    exp_pos = pos_q;
    exp_dir = dir_q;
    if (!dir_q) begin
      if (pos_q == {POS_W{1'b1}}) begin
        exp_pos = pos_q - POS_W'(1);
        exp_dir = 1'b1;
      end else begin
        exp_pos = pos_q + POS_W'(1);
      end
    end else begin
      if (pos_q == {POS_W{1'b0}}) begin
        exp_pos = POS_W'(1);
        exp_dir = 1'b0;
      end else begin
        exp_pos = pos_q - POS_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    sweep_d = sweep_q;
    code_d  = code_q;

    if (clr) begin
      state_d = SYNC;
      sweep_d = '0;
      code_d  = ERR_NONE;
    end else begin
      case (state_q)
        SYNC: begin
          if (change && onehot) begin
            pos_d   = npos;
            state_d = ARM;
          end
        end
        ARM: begin
          if (change) begin
            if (!onehot) begin
              state_d = SYNC;
            end else if (pos_adjacent(pos_q, npos)) begin
              dir_d   = (npos < pos_q);
              pos_d   = npos;
              state_d = TRACK;
            end else begin
              pos_d = npos;
            end
          end
        end
        TRACK: begin
          if (change) begin
            if (!onehot) begin
              state_d = ERROR;
              code_d  = ERR_ONEHOT;
            end else if (npos != exp_pos) begin
              state_d = ERROR;
              code_d  = ERR_STEP;
            end else begin
              pos_d = npos;
              dir_d = exp_dir;
              if ((pos_q == POS_W'(1)) && (npos == '0)) begin
                sweep_d = sweep_q + 8'd1;
              end
            end
          end else if (stall_hit) begin
            state_d = ERROR;
            code_d  = ERR_STALL;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end

    err_d    = (state_d == ERROR);
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q    <= '0;
      state_q  <= SYNC;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      sweep_q  <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      locked_q <= 1'b0;
    end else begin
      led_q    <= led;
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      sweep_q  <= sweep_d;
      err_q    <= err_d;
      code_q   <= code_d;
      locked_q <= locked_d;
    end
  end

  assign pos       = pos_q;
  assign dir       = dir_q;
  assign locked    = locked_q;
  assign sweep_cnt = sweep_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Directed bench for led_pattern_monitor: vector table plus hand sequences
// for stall, sweep counting and asynchronous reset.
module tb_led_pattern_monitor;

  logic        clk;
  logic        reset;
  logic [15:0] led;
  logic        clr;
  logic [3:0]  pos;
  logic        dir;
  logic        locked;
  logic [7:0]  sweep_cnt;
  logic        err;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] led;
    logic        clr;
    int          idle;
    logic [3:0]  pos;
    logic        dir;
    logic        lk;
    logic [7:0]  sw;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  vec_t vt[$];

  led_pattern_monitor #(.STALL_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .led       (led),
    .clr       (clr),
    .pos       (pos),
    .dir       (dir),
    .locked    (locked),
    .sweep_cnt (sweep_cnt),
    .err       (err),
    .err_code  (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] p, input logic d,
                         input logic lk, input logic [7:0] sw, input logic e,
                         input logic [1:0] c);
    chk({nm, ".pos"}, 32'(pos), 32'(p));
    chk({nm, ".dir"}, 32'(dir), 32'(d));
    chk({nm, ".locked"}, 32'(locked), 32'(lk));
    chk({nm, ".sweep"}, 32'(sweep_cnt), 32'(sw));
    chk({nm, ".err"}, 32'(err), 32'(e));
    chk({nm, ".code"}, 32'(err_code), 32'(c));
  endtask

  task automatic add(input logic [15:0] l, input logic c, input int idle,
                     input logic [3:0] p, input logic d, input logic lk,
                     input logic [7:0] sw, input logic e, input logic [1:0] code);
    vec_t v;
    v.led = l; v.clr = c; v.idle = idle; v.pos = p; v.dir = d;
    v.lk = lk; v.sw = sw; v.err = e; v.code = code;
    vt.push_back(v);
  endtask

  task automatic drive(input logic [15:0] v);
    led = v;
    @(negedge clk);
  endtask

  initial begin
    // Lock-in and a full bounce.
    add(16'h0001, 0, 10, 4'd0, 0, 0, 8'd0, 0, 2'd0);
    add(16'h0002, 0, 2,  4'd1, 0, 1, 8'd0, 0, 2'd0);
    add(16'h0004, 0, 3,  4'd2, 0, 1, 8'd0, 0, 2'd0);
    for (int k = 3; k < 16; k++) add(16'h0001 << k, 0, 0, 4'(k), 0, 1, 8'd0, 0, 2'd0);
    for (int k = 14; k >= 1; k--) add(16'h0001 << k, 0, 0, 4'(k), 1, 1, 8'd0, 0, 2'd0);
    add(16'h0001, 0, 0, 4'd0, 1, 1, 8'd1, 0, 2'd0);
    add(16'h0002, 0, 0, 4'd1, 0, 1, 8'd1, 0, 2'd0);
    add(16'h0004, 0, 0, 4'd2, 0, 1, 8'd1, 0, 2'd0);
    add(16'h0008, 0, 0, 4'd3, 0, 1, 8'd1, 0, 2'd0);
    // Not-one-hot error, then later violations must not overwrite the code.
    add(16'h0010, 0, 0, 4'd4, 0, 1, 8'd1, 0, 2'd0);
    add(16'h0030, 0, 0, 4'd4, 0, 0, 8'd1, 1, 2'd1);
    add(16'h0100, 0, 0, 4'd4, 0, 0, 8'd1, 1, 2'd1);
    add(16'h0020, 0, 0, 4'd4, 0, 0, 8'd1, 1, 2'd1);
    add(16'h0020, 1, 0, 4'd4, 0, 0, 8'd0, 0, 2'd0);
    // Illegal step from pos 5 going up.
    add(16'h0010, 0, 0, 4'd4, 0, 0, 8'd0, 0, 2'd0);
    add(16'h0020, 0, 0, 4'd5, 0, 1, 8'd0, 0, 2'd0);
    add(16'h0100, 0, 0, 4'd5, 0, 0, 8'd0, 1, 2'd2);
    // clr together with a change: clr wins, pos held.
    add(16'h0200, 1, 0, 4'd5, 0, 0, 8'd0, 0, 2'd0);
    add(16'h0400, 0, 0, 4'd10, 0, 0, 8'd0, 0, 2'd0);
    add(16'h0100, 0, 0, 4'd8, 0, 0, 8'd0, 0, 2'd0);
    add(16'h0003, 0, 0, 4'd8, 0, 0, 8'd0, 0, 2'd0);
    add(16'h0200, 0, 0, 4'd9, 0, 0, 8'd0, 0, 2'd0);
    add(16'h0100, 0, 0, 4'd8, 1, 1, 8'd0, 0, 2'd0);
    add(16'h0080, 0, 0, 4'd7, 1, 1, 8'd0, 0, 2'd0);
    add(16'h0000, 0, 0, 4'd7, 1, 0, 8'd0, 1, 2'd1);
    add(16'h0000, 1, 0, 4'd7, 1, 0, 8'd0, 0, 2'd0);

    reset = 1'b0;
    clr   = 1'b0;
    led   = 16'h0000;
    #12;
    chk_all("reset", 4'd0, 0, 0, 8'd0, 0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 4'd0, 0, 0, 8'd0, 0, 2'd0);

    for (int i = 0; i < vt.size(); i++) begin
      led = vt[i].led;
      clr = vt[i].clr;
      @(negedge clk);
      clr = 1'b0;
      repeat (vt[i].idle) @(negedge clk);
      chk_all($sformatf("v%0d", i), vt[i].pos, vt[i].dir, vt[i].lk, vt[i].sw,
              vt[i].err, vt[i].code);
    end

    // Stall: a change restarts the count; error exactly 8 idle cycles later.
    drive(16'h0001);
    drive(16'h0002);
    chk("stall_lock", 32'(locked), 32'd1);
    repeat (5) @(negedge clk);
    drive(16'h0004);
    repeat (7) @(negedge clk);
    chk("stall_pre.err", 32'(err), 32'd0);
    @(negedge clk);
`ifdef LED_MON_STALL_EN
    chk_all("stall_hit", 4'd2, 0, 0, 8'd0, 1, 2'd3);
`else
    chk_all("stall_off", 4'd2, 0, 1, 8'd0, 0, 2'd0);
`endif
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_all("stall_clr", 4'd2, 0, 0, 8'd0, 0, 2'd0);

    // Five round trips, then asynchronous reset mid-TRACK.
    drive(16'h0002);
    drive(16'h0004);
    for (int s = 0; s < 5; s++) begin
      for (int k = (s == 0) ? 3 : 1; k < 16; k++) drive(16'h0001 << k);
      for (int k = 14; k >= 0; k--) drive(16'h0001 << k);
    end
    drive(16'h0002);
    chk_all("sweep5", 4'd1, 0, 1, 8'd5, 0, 2'd0);

    #1 reset = 1'b0;
    #1;
    chk_all("async_rst", 4'd0, 0, 0, 8'd0, 0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk_all("rst_hold", 4'd0, 0, 0, 8'd0, 0, 2'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_all("relock1", 4'd1, 0, 0, 8'd0, 0, 2'd0);
    drive(16'h0004);
    chk_all("relock2", 4'd2, 0, 1, 8'd0, 0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
